// File: rtl/nmr_acq_sampler_if.sv
// nmr_acq_sampler_if
//   Output sample stream of the NMR acquisition sampler.
//   OUT_DATA  : captured ADC word
//   OUT_ECHO  : 0-based echo (window) index of the word
//   OUT_LAST  : final word of an acquisition window
//   OUT_VALID : word present; OUT_READY : consumer accepts
//   master = sampler side, slave = DMA/readout side.
interface nmr_acq_sampler_if #(
    parameter int DATA_WIDTH          = 16,
    parameter int ECHO_PER_SCAN_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]          OUT_DATA;
    logic [ECHO_PER_SCAN_WIDTH-1:0] OUT_ECHO;
    logic                           OUT_LAST;
    logic                           OUT_VALID;
    logic                           OUT_READY;

    modport master (
        output OUT_DATA, OUT_ECHO, OUT_LAST, OUT_VALID,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA, OUT_ECHO, OUT_LAST, OUT_VALID,
        output OUT_READY
    );
endinterface

// File: rtl/nmr_acq_sampler.sv
// nmr_acq_sampler
//   Captures ADC_DATA on each ADC_CLK rising edge inside ACQ_WND, tags each
//   word with its echo index, flags the last word of each window, buffers in
//   a first-word-fall-through FIFO and streams it out on out_if.
//   Ports:
//     CLK, RESET (async, active-low)
//     START, ECHO_PER_SCAN : arm pulse and number of windows per scan
//     ACQ_WND, ADC_CLK     : window and sample clock (edge-detected as data)
//     ADC_DATA             : sample word
//     BUSY, DONE, OVERFLOW : scan status; OVERFLOW is sticky until START
//     out_if (master)      : OUT_DATA/OUT_ECHO/OUT_LAST/OUT_VALID/OUT_READY
//   Optional: define NMR_ACQ_DECIM_EN to add DECIM[7:0]; only every
//   (DECIM+1)-th in-window ADC edge is captured.
module nmr_acq_sampler #(
    parameter int DATA_WIDTH          = 16,
    parameter int ECHO_PER_SCAN_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH     = 9
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           START,
    input  logic [ECHO_PER_SCAN_WIDTH-1:0] ECHO_PER_SCAN,
`ifdef NMR_ACQ_DECIM_EN
    input  logic [7:0]                     DECIM,
`endif
    input  logic                           ACQ_WND,
    input  logic                           ADC_CLK,
    input  logic [DATA_WIDTH-1:0]          ADC_DATA,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           OVERFLOW,
    nmr_acq_sampler_if.master              out_if
);
    localparam int EW     = ECHO_PER_SCAN_WIDTH;
    localparam int WORD_W = DATA_WIDTH + EW + 1;
    localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FINISH} state_t;

    state_t state, state_nxt;

    logic adc_q, wnd_q;
    logic adc_rise, wnd_rise, wnd_fall;

    logic [EW-1:0]         echo_cnt, echo_idx, echo_inc;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [EW-1:0]         hold_echo;
    logic                  overflow_q;

    logic start_acc, qual_edge, dec_hit, take, close, push_en, push_last;

    logic [WORD_W-1:0]        mem [DEPTH];
    logic [FIFO_ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic                     empty, full, pop, push_ok;
    logic [WORD_W-1:0]        push_word, rd_word;

    assign adc_rise = ADC_CLK & ~adc_q;
    assign wnd_rise = ACQ_WND & ~wnd_q;
    assign wnd_fall = ~ACQ_WND & wnd_q;
    assign echo_inc = echo_idx + EW'(1);

    // A qualifying edge needs ACQ_WND still high, so an edge coincident
    // with the window falling is never captured.
    assign qual_edge = (state == CAPTURE) && adc_rise && ACQ_WND;

`ifdef NMR_ACQ_DECIM_EN
    logic [7:0] decim_q, dec_cnt;
    assign dec_hit = (dec_cnt == 8'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            decim_q <= '0;
            dec_cnt <= '0;
        end else begin
            if (start_acc)
                decim_q <= DECIM;
            if (wnd_rise)
                dec_cnt <= '0;
            else if (qual_edge)
                dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
        end
    end
`else
    assign dec_hit = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        take      = 1'b0;
        close     = 1'b0;
        push_en   = 1'b0;
        push_last = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    start_acc = 1'b1;
                    state_nxt = (ECHO_PER_SCAN == '0) ? FINISH : ARMED;
                end
            end
            ARMED: begin
                if (wnd_rise) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (wnd_fall) begin
                    close     = 1'b1;
                    push_en   = hold_valid;
                    push_last = 1'b1;
                    state_nxt = (echo_inc == echo_cnt) ? FINISH : ARMED;
                end else if (qual_edge && dec_hit) begin
                    take    = 1'b1;
                    push_en = hold_valid;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY     = (state == ARMED) || (state == CAPTURE);
    assign DONE     = (state == FINISH);
    assign OVERFLOW = overflow_q;

    // The newest sample waits in the hold register so that the window close
    // can mark it LAST before it enters the FIFO.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            adc_q      <= 1'b0;
            wnd_q      <= 1'b0;
            echo_cnt   <= '0;
            echo_idx   <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_echo  <= '0;
            overflow_q <= 1'b0;
        end else begin
            adc_q <= ADC_CLK;
            wnd_q <= ACQ_WND;
            if (start_acc) begin
                echo_cnt   <= ECHO_PER_SCAN;
                echo_idx   <= '0;
                hold_valid <= 1'b0;
            end
            if (take) begin
                hold_data  <= ADC_DATA;
                hold_echo  <= echo_idx;
                hold_valid <= 1'b1;
            end
            if (close) begin
                hold_valid <= 1'b0;
                echo_idx   <= echo_inc;
            end
            if (start_acc)
                overflow_q <= 1'b0;
            else if (push_en && !push_ok)
                overflow_q <= 1'b1;
        end
    end

    assign push_word = {push_last, hold_echo, hold_data};
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                       (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
    assign pop       = !empty && out_if.OUT_READY;
    assign push_ok   = push_en && (!full || pop);
    assign rd_word   = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= push_word;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Outputs are forced to zero while empty so unwritten RAM never leaks out.
    assign out_if.OUT_VALID = !empty;
    assign out_if.OUT_DATA  = empty ? '0 : rd_word[DATA_WIDTH-1:0];
    assign out_if.OUT_ECHO  = empty ? '0 : rd_word[DATA_WIDTH +: EW];
    assign out_if.OUT_LAST  = empty ? 1'b0 : rd_word[WORD_W-1];
endmodule

// File: tb/tb_nmr_acq_sampler.sv
module tb_nmr_acq_sampler;
    localparam int DW = 16;
    localparam int EW = 32;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic [EW-1:0] ECHO_PER_SCAN;
    logic          ACQ_WND;
    logic          ADC_CLK;
    logic [DW-1:0] ADC_DATA;
    logic          BUSY, DONE, OVERFLOW;
`ifdef NMR_ACQ_DECIM_EN
    logic [7:0]    DECIM;
`endif

    nmr_acq_sampler_if #(.DATA_WIDTH(DW), .ECHO_PER_SCAN_WIDTH(EW)) sif ();

    nmr_acq_sampler #(
        .DATA_WIDTH(DW),
        .ECHO_PER_SCAN_WIDTH(EW),
        .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .START(START),
        .ECHO_PER_SCAN(ECHO_PER_SCAN),
`ifdef NMR_ACQ_DECIM_EN
        .DECIM(DECIM),
`endif
        .ACQ_WND(ACQ_WND),
        .ADC_CLK(ADC_CLK),
        .ADC_DATA(ADC_DATA),
        .BUSY(BUSY),
        .DONE(DONE),
        .OVERFLOW(OVERFLOW),
        .out_if(sif.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        logic [EW-1:0] e;
        logic          l;
    } exp_t;

    exp_t    exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      done_cnt = 0;
    logic [DW-1:0] sval = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: compares every transfer against the queue head.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && sif.OUT_VALID === 1'b1 && sif.OUT_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0h echo %0h last %0b, none expected",
                         sif.OUT_DATA, sif.OUT_ECHO, sif.OUT_LAST);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("out_data", 64'(sif.OUT_DATA), 64'(x.d));
                check("out_echo", 64'(sif.OUT_ECHO), 64'(x.e));
                check("out_last", 64'(sif.OUT_LAST), 64'(x.l));
            end
        end
    end

    always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_scan(input int n);
        ECHO_PER_SCAN = EW'(n);
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic adc_edge();
        sval++;
        ADC_DATA = sval;
        ADC_CLK  = 1'b1;
        tick(1);
        ADC_CLK  = 1'b0;
        tick(1);
    endtask

    // One window of n_edges edges (data = running sample number). With
    // coincide set, the last edge rises in the cycle the window falls.
    task automatic run_window(input int n_edges, input bit coincide, input int decim,
                              input int echo, input int max_push);
        int   last_cap;
        int   pushed;
        logic [DW-1:0] base;
        last_cap = -1;
        pushed   = 0;
        base     = sval;
        for (int e = 0; e < n_edges; e++)
            if (!(coincide && e == n_edges - 1) && (e % (decim + 1) == 0)) last_cap = e;
        for (int e = 0; e < n_edges; e++) begin
            if (!(coincide && e == n_edges - 1) && (e % (decim + 1) == 0) && pushed < max_push) begin
                exp_t x;
                x.d = base + DW'(e + 1);
                x.e = EW'(echo);
                x.l = (e == last_cap);
                exp_q.push_back(x);
                pushed++;
            end
        end
        ACQ_WND = 1'b1;
        tick(2);
        for (int e = 0; e < n_edges; e++) begin
            if (coincide && e == n_edges - 1) ACQ_WND = 1'b0;
            adc_edge();
        end
        if (!coincide) begin
            tick(1);
            ACQ_WND = 1'b0;
        end
        tick(2);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
        check(name, 64'(exp_q.size()), 64'd0);
        tick(2);
        check({name, "_valid_low"}, 64'(sif.OUT_VALID), 64'd0);
    endtask

    initial begin
        int d0;
        RESET = 1'b0; START = 1'b0; ECHO_PER_SCAN = '0;
        ACQ_WND = 1'b0; ADC_CLK = 1'b0; ADC_DATA = '0;
        sif.OUT_READY = 1'b1;
`ifdef NMR_ACQ_DECIM_EN
        DECIM = 8'd0;
`endif
        tick(3);
        check("rst_valid", 64'(sif.OUT_VALID), 64'd0);
        check("rst_data", 64'(sif.OUT_DATA), 64'd0);
        check("rst_last", 64'(sif.OUT_LAST), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_ovf", 64'(OVERFLOW), 64'd0);
        RESET = 1'b1;
        tick(2);

        // 1: three windows of 8, with a START issued mid-scan that must be ignored
        d0 = done_cnt;
        start_scan(3);
        check("t1_busy", 64'(BUSY), 64'd1);
        run_window(8, 1'b0, 0, 0, 99);
        start_scan(7);
        run_window(8, 1'b0, 0, 1, 99);
        check("t1_busy_mid", 64'(BUSY), 64'd1);
        run_window(8, 1'b0, 0, 2, 99);
        tick(2);
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check("t1_busy_end", 64'(BUSY), 64'd0);
        drain("t1_drain");

        // ECHO_PER_SCAN = 0: immediate DONE, nothing captured
        d0 = done_cnt;
        start_scan(0);
        tick(2);
        check("t0echo_done", 64'(done_cnt - d0), 64'd1);
        check("t0echo_busy", 64'(BUSY), 64'd0);

        // 2: no readiness, 20 edges into a 16-deep FIFO
        sif.OUT_READY = 1'b0;
        start_scan(1);
        run_window(20, 1'b0, 0, 0, 16);
        tick(2);
        check("t2_ovf", 64'(OVERFLOW), 64'd1);
        check("t2_valid", 64'(sif.OUT_VALID), 64'd1);
        sif.OUT_READY = 1'b1;
        drain("t2_drain");
        check("t2_ovf_sticky", 64'(OVERFLOW), 64'd1);

        // 3: window already open at arm time is ignored
        ACQ_WND = 1'b1;
        tick(2);
        adc_edge();
        start_scan(1);
        check("t3_ovf_cleared", 64'(OVERFLOW), 64'd0);
        adc_edge();
        ACQ_WND = 1'b0;
        tick(3);
        check("t3_busy", 64'(BUSY), 64'd1);
        run_window(4, 1'b0, 0, 0, 99);
        drain("t3_drain");

        // 4: fifth edge coincides with the window fall
        start_scan(1);
        run_window(5, 1'b1, 0, 0, 99);
        drain("t4_drain");

        // 5: reset mid-window
        sif.OUT_READY = 1'b0;
        start_scan(2);
        ACQ_WND = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) adc_edge();
        check("t5_valid_pre", 64'(sif.OUT_VALID), 64'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("t5_valid_rst", 64'(sif.OUT_VALID), 64'd0);
        check("t5_busy_rst", 64'(BUSY), 64'd0);
        ACQ_WND = 1'b0;
        tick(2);
        RESET = 1'b1;
        sif.OUT_READY = 1'b1;
        tick(2);
        start_scan(1);
        run_window(2, 1'b0, 0, 0, 99);
        drain("t5_drain");
        check("t5_ovf", 64'(OVERFLOW), 64'd0);

`ifdef NMR_ACQ_DECIM_EN
        // 6: decimation by 3, edges 1, 4, 7 of 9
        DECIM = 8'd2;
        start_scan(1);
        run_window(9, 1'b0, 2, 0, 99);
        drain("t6_drain");
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nmr_acq_sampler.md
Name: nmr_acq_sampler

Overview:
Downstream consumer of the NMR pulse programmer's ACQ_WND and ADC_CLK outputs.
- Captures one ADC_DATA word on every ADC_CLK rising edge while the acquisition window is open.
- Tags each word with its echo index and flags the last sample of each window.
- Buffers words in a first-word-fall-through FIFO and presents them on a valid/ready stream for the DMA/readout stage.
- Counts windows against ECHO_PER_SCAN and signals scan completion.

Parameters:
DATA_WIDTH, 16, ADC sample width.
ECHO_PER_SCAN_WIDTH, 32, width of echo count and echo index.
FIFO_ADDR_WIDTH, 9, FIFO depth = 2^FIFO_ADDR_WIDTH words (512).

Ports:
CLK  in  1  system clock; ADC_CLK and ACQ_WND are generated synchronously to it.
RESET  in  1  asynchronous, active-low reset.
START  in  1  one-cycle arm pulse, same pulse as fed to the pulse programmer.
ECHO_PER_SCAN  in  ECHO_PER_SCAN_WIDTH  number of acquisition windows per scan; latched on START.
ACQ_WND  in  1  acquisition window from the pulse programmer.
ADC_CLK  in  1  ADC sample clock from the pulse programmer; treated as data and edge-detected.
ADC_DATA  in  DATA_WIDTH  ADC output word, valid at the ADC_CLK rising edge.
OUT_DATA  out  DATA_WIDTH  stream sample.
OUT_ECHO  out  ECHO_PER_SCAN_WIDTH  echo index of the sample, 0-based.
OUT_LAST  out  1  high on the final sample of a window.
OUT_VALID  out  1  stream valid.
OUT_READY  in  1  stream ready; a transfer occurs when OUT_VALID and OUT_READY are both high.
BUSY  out  1  high from START acceptance until DONE.
DONE  out  1  one-cycle pulse after the final window closes.
OVERFLOW  out  1  sticky flag: a sample was dropped on FIFO full.

Behaviour:
Reset:
- All outputs 0. FSM in IDLE. FIFO empty. Hold register invalid. Edge registers 0.

Edge detection:
- adc_q and wnd_q are 1-cycle delayed copies of ADC_CLK and ACQ_WND.
- adc_rise = ADC_CLK & ~adc_q.
- wnd_rise = ACQ_WND & ~wnd_q.
- wnd_fall = ~ACQ_WND & wnd_q.

FSM states:
- IDLE: START latches ECHO_PER_SCAN, clears echo_idx, sample count and OVERFLOW, sets BUSY, and moves to ARMED.
  - START with ECHO_PER_SCAN = 0: DONE pulses on the next cycle and the FSM returns to IDLE.
- ARMED: wait for wnd_rise, then go to CAPTURE. A window already high at arm time is ignored until it falls and rises again.
- CAPTURE:
  - On adc_rise with ACQ_WND = 1: if the hold register is valid, push it to the FIFO with LAST = 0. Then load ADC_DATA into the hold register with the current echo_idx, and mark it valid. Latency from ADC edge to hold register is 1 cycle.
  - On wnd_fall: if the hold register is valid, push it with LAST = 1 and invalidate it. Then increment echo_idx.
    - If echo_idx + 1 equals the latched count, go to FINISH.
    - Otherwise go to ARMED.
  - A window containing zero samples pushes nothing but still counts as an echo.
- FINISH: DONE = 1 for one cycle, BUSY = 0, then IDLE.
  - The FIFO may still hold data; draining continues in IDLE.

Simultaneous events:
- adc_rise in the same cycle as wnd_fall (ACQ_WND already 0): the sample is not captured.
- START while BUSY: ignored.

FIFO:
- First-word fall-through. OUT_VALID rises the cycle after the first push into an empty FIFO.
- Each word is DATA_WIDTH + ECHO_PER_SCAN_WIDTH + 1 bits.
- A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- Otherwise the word is dropped and OVERFLOW sets. OVERFLOW clears only on an accepted START or on reset.
- OUT_* is stable while OUT_VALID = 1 and OUT_READY = 0.
- Pointer widths are FIFO_ADDR_WIDTH + 1, using the wrap bit to distinguish full from empty.

Width rules:
- echo_idx is ECHO_PER_SCAN_WIDTH bits and cannot wrap, because the count is bounded by the latched ECHO_PER_SCAN.

Reset mid-operation:
- Asynchronous. The FIFO is flushed, the partial window is discarded, and the FSM returns to IDLE.

Optional Feature:
NMR_ACQ_DECIM_EN:
- When defined, adds input port DECIM (8 bits, latched on START).
- Only every (DECIM + 1)-th qualifying ADC edge is captured. The decimation counter resets on every wnd_rise, so the first edge of each window is always captured.
- When not defined: no DECIM port, and every edge inside the window is captured.

Test Plan:
1. ECHO_PER_SCAN = 3, three windows of 8 ADC edges each, OUT_READY = 1.
   -> 24 words; OUT_ECHO = 0,0..,1..,2; OUT_LAST on words 8, 16, 24; one DONE pulse after the third wnd_fall; BUSY low afterwards.
2. OUT_READY = 0 throughout, FIFO_ADDR_WIDTH = 4, one window of 20 edges.
   -> 16 words stored; OVERFLOW = 1; draining yields samples 1..16; the final word has no LAST (LAST was dropped).
3. ACQ_WND already high when START arrives, then falls and rises for a 4-edge window.
   -> only the 4 edges from the second window are captured; OUT_ECHO = 0.
4. adc_rise coincident with wnd_fall, window of 5 edges where the 5th coincides with the fall.
   -> 4 words; the 4th carries OUT_LAST.
5. RESET asserted mid-window after 3 samples, then a new START with ECHO_PER_SCAN = 1 and a 2-edge window.
   -> OUT_VALID = 0 immediately on reset; afterwards 2 words with echo 0, LAST on the second; OVERFLOW = 0.
6. With NMR_ACQ_DECIM_EN, DECIM = 2, 9-edge window.
   -> 3 words (edges 1, 4, 7); LAST on the edge-7 word.
